game_timer: RTL and testbench

- Sits directly downstream of the free-running 25-bit cycle counter. That counter counts 0..25000000 at 25 MHz, then wraps to 0.
- Turns the raw count into game-time events for the VGA runner game:
  - a 1 s tick,
  - a 4-digit BCD survival-time score,
  - a difficulty level,
  - a level-dependent obstacle step pulse.
- Owns the game run-state machine (IDLE/RUN/PAUSE/OVER) consumed by the renderer and score display.

---
 rtl/game_timer_if.sv | 27 ++
 rtl/game_timer.sv | 151 +++++++++++++++
 tb/tb_game_timer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_timer_if.sv
// game_timer_if: bundles the game-input and game-event signals of game_timer.
// There is no valid/ready handshake on this bus. The master drives count, start,
// pause and hit as plain levels that are sampled on every clock. The slave drives
// tick_sec and step_tick as one-cycle pulses, and sec_bcd, level, state and
// game_over as registered levels.
interface game_timer_if;
    logic [24:0] count;
    logic        start;
    logic        pause;
    logic        hit;
    logic        tick_sec;
    logic        step_tick;
    logic [15:0] sec_bcd;
    logic [2:0]  level;
    logic [1:0]  state;
    logic        game_over;

    modport master (
        output count, start, pause, hit,
        input  tick_sec, step_tick, sec_bcd, level, state, game_over
    );

    modport slave (
        input  count, start, pause, hit,
        output tick_sec, step_tick, sec_bcd, level, state, game_over
    );
endinterface

// File: rtl/game_timer.sv
// game_timer: derives game-time events from the free-running cycle counter.
// It produces the 1 s tick, the BCD survival score, the difficulty level and
// the obstacle step pulse. It also owns the IDLE/RUN/PAUSE/OVER run-state machine.
// The state output doubles as the FSM debug view.
module game_timer #(
    parameter int TICK_VAL   = 25000000,
    parameter int LEVEL_SECS = 10,
    parameter int MAX_LEVEL  = 7,
    parameter int STEP_BASE  = 19
) (
    input  logic         clk,
    input  logic         rst,
    game_timer_if.slave  gt_bus
);

    localparam int LC_W = (LEVEL_SECS > 1) ? $clog2(LEVEL_SECS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    state_t          r_state;
    logic            r_start_d;
    logic            r_pause_d;
    logic            r_tick_sec;
    logic            r_step_tick;
    logic [15:0]     r_sec_bcd;
    logic [2:0]      r_level;
    logic [LC_W-1:0] r_lvl_cnt;
    logic            r_game_over;

    logic            w_start_r;
    logic            w_pause_r;
    logic            w_cnt_ok;
    logic            w_sec_ev;
    logic [24:0]     w_step_mask;
    logic            w_step_ev;

    // Saturating 4-digit BCD increment: 9999 stays 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] res;
        logic        carry;
        res   = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (res[i*4 +: 4] == 4'd9) begin
                        res[i*4 +: 4] = 4'd0;
                    end else begin
                        res[i*4 +: 4] = res[i*4 +: 4] + 4'd1;
                        carry         = 1'b0;
                    end
                end
            end
        end
        return res;
    endfunction

    // Button rising edges and count-derived events, used in the cycle they are seen.
    // Out-of-range count values are rejected, so they raise neither tick nor step.
    always_comb begin
        w_start_r   = gt_bus.start & ~r_start_d;
        w_pause_r   = gt_bus.pause & ~r_pause_d;
        w_cnt_ok    = (gt_bus.count <= 25'(TICK_VAL));
        w_sec_ev    = (gt_bus.count == 25'(TICK_VAL));
        w_step_mask = ~(25'h1FF_FFFF << (STEP_BASE + 1 - int'(r_level)));
        w_step_ev   = w_cnt_ok && ((gt_bus.count & w_step_mask) == 25'd0);
    end

    // Run-state machine together with all registered outputs and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_start_d   <= 1'b0;
            r_pause_d   <= 1'b0;
            r_tick_sec  <= 1'b0;
            r_step_tick <= 1'b0;
            r_sec_bcd   <= 16'h0000;
            r_level     <= 3'd0;
            r_lvl_cnt   <= '0;
            r_game_over <= 1'b0;
        end else begin
            r_start_d   <= gt_bus.start;
            r_pause_d   <= gt_bus.pause;
            r_tick_sec  <= w_sec_ev;
            r_step_tick <= 1'b0;
            r_game_over <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_sec_bcd <= 16'h0000;
                    r_level   <= 3'd0;
                    r_lvl_cnt <= '0;
                    if (w_start_r) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (gt_bus.hit) begin
                        r_state     <= ST_OVER;
                        r_game_over <= 1'b1;
                    end else if (w_pause_r) begin
                        r_state <= ST_PAUSE;
                    end else begin
                        r_step_tick <= w_step_ev;
                        if (w_sec_ev) begin
                            r_sec_bcd <= bcd_inc(r_sec_bcd);
                            if (r_lvl_cnt == LC_W'(LEVEL_SECS - 1)) begin
                                r_lvl_cnt <= '0;
                                if (r_level != 3'(MAX_LEVEL)) begin
                                    r_level <= r_level + 3'd1;
                                end
                            end else begin
                                r_lvl_cnt <= r_lvl_cnt + 1'b1;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (w_pause_r || w_start_r) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_OVER: begin
                    if (w_start_r) begin
                        r_state   <= ST_RUN;
                        r_sec_bcd <= 16'h0000;
                        r_level   <= 3'd0;
                        r_lvl_cnt <= '0;
                    end else begin
                        r_game_over <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gt_bus.tick_sec  = r_tick_sec;
    assign gt_bus.step_tick = r_step_tick;
    assign gt_bus.sec_bcd   = r_sec_bcd;
    assign gt_bus.level     = r_level;
    assign gt_bus.state     = r_state;
    assign gt_bus.game_over = r_game_over;

endmodule

// File: tb/tb_game_timer.sv
// tb_game_timer: table vectors, hand-written corner sequences and a random run,
// all checked against a behavioural model of the game timer.
module tb_game_timer;
    localparam int TICK_VAL = 25000000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    game_timer_if bus_if();

    game_timer dut (
        .clk    (clk),
        .rst    (rst),
        .gt_bus (bus_if)
    );

    // Clock and reset-time input defaults
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int step_seen = 0;

    // Model state: seconds counted since the last clear, unsaturated.
    int m_state;
    int m_secs;
    bit m_tick;
    bit m_step;
    bit m_prev_s;
    bit m_prev_p;

    // Expected outputs: {tick, step, bcd[15:0], level[2:0], state[1:0], game_over}
    logic [23:0] exp_q[$];

    typedef struct {
        logic [24:0] count;
        bit          start;
        bit          pause;
        bit          hit;
        bit          tick;
        bit          step;
        logic [15:0] bcd;
        logic [2:0]  level;
        logic [1:0]  state;
        bit          go;
    } vec_t;

    vec_t tbl[16];

    function automatic logic [15:0] to_bcd(input int n);
        int v;
        v = (n > 9999) ? 9999 : n;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int m_level();
        return (m_secs / 10 > 7) ? 7 : m_secs / 10;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input logic [24:0] c, input bit s,
                                input bit p, input bit h);
        bit sr, pr, sec, stepev;
        int lvl;
        if (r) begin
            m_state = 0; m_secs = 0; m_tick = 0; m_step = 0;
            m_prev_s = 0; m_prev_p = 0;
        end else begin
            sr     = s && !m_prev_s;
            pr     = p && !m_prev_p;
            sec    = (int'(c) == TICK_VAL);
            lvl    = m_level();
            stepev = (int'(c) <= TICK_VAL) && ((int'(c) % (1 << (20 - lvl))) == 0);
            m_tick = sec;
            m_step = 0;
            case (m_state)
                0: begin
                    m_secs = 0;
                    if (sr) m_state = 1;
                end
                1: begin
                    if (h) m_state = 3;
                    else if (pr) m_state = 2;
                    else begin
                        if (sec) m_secs++;
                        m_step = stepev;
                    end
                end
                2: begin
                    if (pr || sr) m_state = 1;
                end
                default: begin
                    if (sr) begin
                        m_state = 1;
                        m_secs  = 0;
                    end
                end
            endcase
            m_prev_s = s;
            m_prev_p = p;
        end
        exp_q.push_back({m_tick, m_step, to_bcd(m_secs), 3'(m_level()), 2'(m_state),
                         (m_state == 3)});
    endtask

    task automatic compare_model();
        logic [23:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard: got empty queue expected one entry");
        end else begin
            e = exp_q.pop_front();
            check("tick_sec",  32'(bus_if.tick_sec),  32'(e[23]));
            check("step_tick", 32'(bus_if.step_tick), 32'(e[22]));
            check("sec_bcd",   32'(bus_if.sec_bcd),   32'(e[21:6]));
            check("level",     32'(bus_if.level),     32'(e[5:3]));
            check("state",     32'(bus_if.state),     32'(e[2:1]));
            check("game_over", 32'(bus_if.game_over), 32'(e[0]));
        end
    endtask

    // Driver: one clock with the given inputs, then compare against the model.
    task automatic cycle(input logic [24:0] c, input bit s, input bit p, input bit h, input bit r);
        @(negedge clk);
        rst          = r;
        bus_if.count = c;
        bus_if.start = s;
        bus_if.pause = p;
        bus_if.hit   = h;
        @(posedge clk);
        model_update(r, c, s, p, h);
        #1;
        compare_model();
        if (bus_if.step_tick) step_seen++;
    endtask

    task automatic run(input logic [24:0] c, input bit s, input bit p, input bit h);
        cycle(c, s, p, h, 1'b0);
    endtask

    task automatic do_reset();
        cycle(25'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(25'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) run(25'(TICK_VAL), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sweep_steps();
        for (int k = 0; k <= 16; k++) run(25'(k * 131072), 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus_if.count = '0;
        bus_if.start = 1'b0;
        bus_if.pause = 1'b0;
        bus_if.hit   = 1'b0;

        // count start pause hit | tick step bcd level state go
        tbl[0]  = '{25'd24999999, 0, 0, 0, 0, 0, 16'h0000, 3'd0, 2'd0, 0};
        tbl[1]  = '{25'd25000000, 0, 0, 0, 1, 0, 16'h0000, 3'd0, 2'd0, 0};
        tbl[2]  = '{25'd0,        0, 0, 0, 0, 0, 16'h0000, 3'd0, 2'd0, 0};
        tbl[3]  = '{25'd1,        1, 0, 0, 0, 0, 16'h0000, 3'd0, 2'd1, 0};
        tbl[4]  = '{25'd2,        1, 0, 0, 0, 0, 16'h0000, 3'd0, 2'd1, 0};
        tbl[5]  = '{25'd25000000, 1, 0, 0, 1, 0, 16'h0001, 3'd0, 2'd1, 0};
        tbl[6]  = '{25'd0,        1, 0, 0, 0, 1, 16'h0001, 3'd0, 2'd1, 0};
        tbl[7]  = '{25'd5,        1, 0, 0, 0, 0, 16'h0001, 3'd0, 2'd1, 0};
        tbl[8]  = '{25'd25000000, 0, 0, 1, 1, 0, 16'h0001, 3'd0, 2'd3, 1};
        tbl[9]  = '{25'd0,        1, 0, 0, 0, 0, 16'h0000, 3'd0, 2'd1, 0};
        tbl[10] = '{25'd7,        0, 1, 0, 0, 0, 16'h0000, 3'd0, 2'd2, 0};
        tbl[11] = '{25'd25000000, 0, 1, 1, 1, 0, 16'h0000, 3'd0, 2'd2, 0};
        tbl[12] = '{25'd0,        0, 0, 0, 0, 0, 16'h0000, 3'd0, 2'd2, 0};
        tbl[13] = '{25'd3,        0, 1, 0, 0, 0, 16'h0000, 3'd0, 2'd1, 0};
        tbl[14] = '{25'd25000000, 0, 0, 0, 1, 0, 16'h0001, 3'd0, 2'd1, 0};
        tbl[15] = '{25'd9,        1, 1, 0, 0, 0, 16'h0001, 3'd0, 2'd2, 0};

        do_reset();
        check("reset_state",   32'(bus_if.state),     32'd0);
        check("reset_bcd",     32'(bus_if.sec_bcd),   32'd0);
        check("reset_level",   32'(bus_if.level),     32'd0);
        check("reset_tick",    32'(bus_if.tick_sec),  32'd0);
        check("reset_step",    32'(bus_if.step_tick), 32'd0);
        check("reset_go",      32'(bus_if.game_over), 32'd0);

        // Table-driven vectors
        for (int i = 0; i < 16; i++) begin
            run(tbl[i].count, tbl[i].start, tbl[i].pause, tbl[i].hit);
            check($sformatf("vec%0d_tick", i),  32'(bus_if.tick_sec),  32'(tbl[i].tick));
            check($sformatf("vec%0d_step", i),  32'(bus_if.step_tick), 32'(tbl[i].step));
            check($sformatf("vec%0d_bcd", i),   32'(bus_if.sec_bcd),   32'(tbl[i].bcd));
            check($sformatf("vec%0d_level", i), 32'(bus_if.level),     32'(tbl[i].level));
            check($sformatf("vec%0d_state", i), 32'(bus_if.state),     32'(tbl[i].state));
            check($sformatf("vec%0d_go", i),    32'(bus_if.game_over), 32'(tbl[i].go));
        end

        // Score carry chain, saturation and level saturation
        do_reset();
        run(25'd1, 1'b1, 1'b0, 1'b0);
        run(25'd2, 1'b0, 1'b0, 1'b0);
        tick_n(10);
        check("ten_sec_bcd",   32'(bus_if.sec_bcd), 32'h0010);
        check("ten_sec_level", 32'(bus_if.level),   32'd1);
        tick_n(89);
        check("bcd_0099", 32'(bus_if.sec_bcd), 32'h0099);
        tick_n(1);
        check("bcd_0100", 32'(bus_if.sec_bcd), 32'h0100);
        tick_n(9899);
        check("bcd_9999", 32'(bus_if.sec_bcd), 32'h9999);
        tick_n(1);
        check("bcd_sat",   32'(bus_if.sec_bcd), 32'h9999);
        check("level_sat", 32'(bus_if.level),   32'd7);

        // Hit coinciding with a second event, then restart
        run(25'(TICK_VAL), 1'b0, 1'b0, 1'b1);
        check("hit_state", 32'(bus_if.state),     32'd3);
        check("hit_go",    32'(bus_if.game_over), 32'd1);
        check("hit_bcd",   32'(bus_if.sec_bcd),   32'h9999);
        run(25'd0, 1'b1, 1'b0, 1'b0);
        check("restart_state", 32'(bus_if.state),   32'd1);
        check("restart_bcd",   32'(bus_if.sec_bcd), 32'h0000);
        check("restart_level", 32'(bus_if.level),   32'd0);

        // Pause freezes the score, resume continues from it
        run(25'd1, 1'b0, 1'b0, 1'b0);
        tick_n(5);
        run(25'd1, 1'b0, 1'b1, 1'b0);
        check("pause_state", 32'(bus_if.state), 32'd2);
        run(25'(TICK_VAL), 1'b0, 1'b1, 1'b1);
        run(25'(TICK_VAL), 1'b0, 1'b0, 1'b0);
        check("pause_frozen", 32'(bus_if.sec_bcd), 32'h0005);
        check("pause_held",   32'(bus_if.state),   32'd2);
        run(25'd1, 1'b0, 1'b1, 1'b0);
        check("resume_state", 32'(bus_if.state), 32'd1);
        tick_n(1);
        check("resume_bcd", 32'(bus_if.sec_bcd), 32'h0006);

        // Out-of-range counts raise neither tick nor step
        run(25'd25000001, 1'b0, 1'b0, 1'b0);
        run(25'd32505856, 1'b0, 1'b0, 1'b0);
        check("oor_step", 32'(bus_if.step_tick), 32'd0);
        run(25'd3, 1'b0, 1'b0, 1'b0);
        check("oor_tick", 32'(bus_if.tick_sec), 32'd0);

        // Step spacing at level 0 and level 3, none while paused
        do_reset();
        run(25'd1, 1'b1, 1'b0, 1'b0);
        run(25'd5, 1'b0, 1'b0, 1'b0);
        step_seen = 0;
        sweep_steps();
        check("steps_level0", 32'(step_seen), 32'd3);
        tick_n(30);
        check("level3", 32'(bus_if.level), 32'd3);
        step_seen = 0;
        sweep_steps();
        check("steps_level3", 32'(step_seen), 32'd17);
        run(25'd1, 1'b0, 1'b1, 1'b0);
        step_seen = 0;
        sweep_steps();
        check("steps_paused", 32'(step_seen), 32'd0);

        // Reset in the middle of a run
        do_reset();
        run(25'd1, 1'b1, 1'b0, 1'b0);
        run(25'd2, 1'b0, 1'b0, 1'b0);
        tick_n(42);
        check("pre_rst_bcd", 32'(bus_if.sec_bcd), 32'h0042);
        cycle(25'(TICK_VAL), 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_state", 32'(bus_if.state),     32'd0);
        check("rst_bcd",   32'(bus_if.sec_bcd),   32'd0);
        check("rst_tick",  32'(bus_if.tick_sec),  32'd0);
        check("rst_level", 32'(bus_if.level),     32'd0);
        run(25'd0, 1'b0, 1'b0, 1'b0);
        check("post_rst_tick", 32'(bus_if.tick_sec), 32'd0);

        // Random stimulus against the model
        for (int n = 0; n < 4000; n++) begin
            logic [24:0] c;
            bit s, p, h, r;
            case ($urandom_range(0, 5))
                0, 1:    c = 25'(TICK_VAL);
                2:       c = 25'($urandom_range(0, 255) * 8192);
                3:       c = 25'd0;
                4:       c = 25'($urandom_range(0, TICK_VAL));
                default: c = 25'($urandom_range(TICK_VAL + 1, 33554431));
            endcase
            s = ($urandom_range(0, 9) == 0);
            p = ($urandom_range(0, 11) == 0);
            h = ($urandom_range(0, 39) == 0);
            r = ($urandom_range(0, 499) == 0);
            cycle(c, s, p, h, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
